// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared types and defaults for the divider sequencer.
//   div_state_e  - sequencer state encoding (3-bit)
//   DefaultDataW - default operand/result width
//   DefaultLatW  - default width of the saturating latency counter
// Core result layout: dout_tdata = {remainder, quotient}, quotient in the low half.
package div_ctrl_pkg;

   localparam int unsigned DefaultDataW = 32;
   localparam int unsigned DefaultLatW  = 6;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StIssue = 3'd1,
      StWait  = 3'd2,
      StDone  = 3'd3,
      StDrain = 3'd4
   } div_state_e;

endpackage

// File: rtl/div_ctrl_axis_src_hs.sv
// axis_src_hs: one AXI-stream source channel of the divider operand interface.
// Holds a pending flag that is set by start and cleared on the tvalid&tready
// handshake; tvalid is the registered pending flag itself.
//   clk    - clock
//   reset  - asynchronous, active-high
//   start  - arm the channel (new operation accepted)
//   tready - ready of the core currently selected
//   tvalid - operand valid, before steering to a core
//   fire   - handshake completes this cycle
module axis_src_hs (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic tready,
   output logic tvalid,
   output logic fire
);

   logic pending_q;
   logic pending_d;

   always_comb begin
      pending_d = pending_q;
      if (start) begin
         pending_d = 1'b1;
      end else if (pending_q && tready) begin
         pending_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending_q <= 1'b0;
      end else begin
         pending_q <= pending_d;
      end
   end

   assign tvalid = pending_q;
   assign fire   = pending_q & tready;

endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: sequencer between the execute stage and the signed/unsigned divider cores.
// Latches one request, handshakes both operand channels to the selected core, waits for
// the result and holds it until accepted. A flush kills the operation; any result still
// in flight is drained and discarded.
//   clk, reset                  - clock, asynchronous active-high reset
//   req_*                       - request from the execute stage
//   flush                       - kill the current operation
//   res_accept                  - consumer takes the result
//   done, quot, rem             - registered result and its valid
//   busy, lat_cnt               - status: not idle, saturating issue-to-dout cycle count
//   dividend_tdata/divisor_tdata- operands shared by both cores
//   s_*/u_* tvalid/tready       - operand handshakes for the signed/unsigned core
//   s_dout_*/u_dout_*           - core results {rem, quot}
module div_ctrl
   import div_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W = DefaultDataW,
   parameter int unsigned LAT_W  = DefaultLatW
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid,
   input  logic                req_signed,
   input  logic [DATA_W-1:0]   req_dividend,
   input  logic [DATA_W-1:0]   req_divisor,
   input  logic                flush,
   input  logic                res_accept,
   output logic                done,
   output logic [DATA_W-1:0]   quot,
   output logic [DATA_W-1:0]   rem,
   output logic                busy,
   output logic [LAT_W-1:0]    lat_cnt,
   output logic [DATA_W-1:0]   dividend_tdata,
   output logic [DATA_W-1:0]   divisor_tdata,
   output logic                s_dividend_tvalid,
   output logic                s_divisor_tvalid,
   output logic                u_dividend_tvalid,
   output logic                u_divisor_tvalid,
   input  logic                s_dividend_tready,
   input  logic                s_divisor_tready,
   input  logic                u_dividend_tready,
   input  logic                u_divisor_tready,
   input  logic                s_dout_tvalid,
   input  logic [2*DATA_W-1:0] s_dout_tdata,
   input  logic                u_dout_tvalid,
   input  logic [2*DATA_W-1:0] u_dout_tdata
);

   div_state_e        state_q, state_d;
   logic              sel_signed_q, sel_signed_d;
   logic              kill_q, kill_d;
   logic [DATA_W-1:0] dividend_q, dividend_d;
   logic [DATA_W-1:0] divisor_q, divisor_d;
   logic [DATA_W-1:0] quot_q, quot_d;
   logic [DATA_W-1:0] rem_q, rem_d;
   logic [LAT_W-1:0]  lat_q, lat_d;

   logic                start;
   logic                dvd_tready, dvs_tready;
   logic                dvd_tvalid, dvs_tvalid;
   logic                dvd_fire, dvs_fire;
   logic                issue_done;
   logic                dout_valid_sel;
   logic [2*DATA_W-1:0] dout_data_sel;

   assign start = (state_q == StIdle) && req_valid && !flush;

   // Readies and results come from the core chosen by the latched request only.
   assign dvd_tready     = sel_signed_q ? s_dividend_tready : u_dividend_tready;
   assign dvs_tready     = sel_signed_q ? s_divisor_tready  : u_divisor_tready;
   assign dout_valid_sel = sel_signed_q ? s_dout_tvalid     : u_dout_tvalid;
   assign dout_data_sel  = sel_signed_q ? s_dout_tdata      : u_dout_tdata;

   axis_src_hs u_dividend_hs (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .tready (dvd_tready),
      .tvalid (dvd_tvalid),
      .fire   (dvd_fire)
   );

   axis_src_hs u_divisor_hs (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .tready (dvs_tready),
      .tvalid (dvs_tvalid),
      .fire   (dvs_fire)
   );

   // Both channels finished, including both completing in this same cycle.
   assign issue_done = (!dvd_tvalid || dvd_fire) && (!dvs_tvalid || dvs_fire);

   always_comb begin
      state_d      = state_q;
      sel_signed_d = sel_signed_q;
      kill_d       = kill_q;
      dividend_d   = dividend_q;
      divisor_d    = divisor_q;
      quot_d       = quot_q;
      rem_d        = rem_q;
      lat_d        = lat_q;

      if ((state_q == StIssue || state_q == StWait) && lat_q != {LAT_W{1'b1}}) begin
         lat_d = lat_q + LAT_W'(1);
      end

      case (state_q)
         StIdle: begin
            kill_d = 1'b0;
            if (start) begin
               sel_signed_d = req_signed;
               dividend_d   = req_dividend;
               divisor_d    = req_divisor;
               lat_d        = '0;
               state_d      = StIssue;
            end
         end
         StIssue: begin
            // tvalid cannot be withdrawn once raised; remember the kill instead.
            if (flush) begin
               kill_d = 1'b1;
            end
            if (issue_done) begin
               state_d = (kill_q || flush) ? StDrain : StWait;
            end
         end
         StWait: begin
            if (dout_valid_sel) begin
               if (flush) begin
                  state_d = StIdle;
               end else begin
                  quot_d  = dout_data_sel[DATA_W-1:0];
                  rem_d   = dout_data_sel[2*DATA_W-1:DATA_W];
                  state_d = StDone;
               end
            end else if (flush) begin
               state_d = StDrain;
            end
         end
         StDone: begin
            if (flush || res_accept) begin
               state_d = StIdle;
            end
         end
         StDrain: begin
            if (dout_valid_sel) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         sel_signed_q <= 1'b0;
         kill_q       <= 1'b0;
         dividend_q   <= '0;
         divisor_q    <= '0;
         quot_q       <= '0;
         rem_q        <= '0;
         lat_q        <= '0;
      end else begin
         state_q      <= state_d;
         sel_signed_q <= sel_signed_d;
         kill_q       <= kill_d;
         dividend_q   <= dividend_d;
         divisor_q    <= divisor_d;
         quot_q       <= quot_d;
         rem_q        <= rem_d;
         lat_q        <= lat_d;
      end
   end

   assign done    = (state_q == StDone);
   assign busy    = (state_q != StIdle);
   assign quot    = quot_q;
   assign rem     = rem_q;
   assign lat_cnt = lat_q;

   assign dividend_tdata = dividend_q;
   assign divisor_tdata  = divisor_q;

   assign s_dividend_tvalid = dvd_tvalid &  sel_signed_q;
   assign s_divisor_tvalid  = dvs_tvalid &  sel_signed_q;
   assign u_dividend_tvalid = dvd_tvalid & ~sel_signed_q;
   assign u_divisor_tvalid  = dvs_tvalid & ~sel_signed_q;

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed bench for div_ctrl. The divider cores are modelled by the bench:
// each core captures operands on its handshakes and returns {rem, quot} when pulsed.
// Expected results are queued when a request that should complete is driven and popped
// when done is observed.
module tb_div_ctrl;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned LAT_W  = 6;

   logic                clk = 1'b0;
   logic                reset;
   logic                req_valid, req_signed;
   logic [DATA_W-1:0]   req_dividend, req_divisor;
   logic                flush, res_accept;
   logic                done, busy;
   logic [DATA_W-1:0]   quot, rem;
   logic [LAT_W-1:0]    lat_cnt;
   logic [DATA_W-1:0]   dividend_tdata, divisor_tdata;
   logic                s_dividend_tvalid, s_divisor_tvalid;
   logic                u_dividend_tvalid, u_divisor_tvalid;
   logic                s_dividend_tready, s_divisor_tready;
   logic                u_dividend_tready, u_divisor_tready;
   logic                s_dout_tvalid, u_dout_tvalid;
   logic [2*DATA_W-1:0] s_dout_tdata, u_dout_tdata;

   always #5 clk = ~clk;

   div_ctrl #(
      .DATA_W (DATA_W),
      .LAT_W  (LAT_W)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .req_valid         (req_valid),
      .req_signed        (req_signed),
      .req_dividend      (req_dividend),
      .req_divisor       (req_divisor),
      .flush             (flush),
      .res_accept        (res_accept),
      .done              (done),
      .quot              (quot),
      .rem               (rem),
      .busy              (busy),
      .lat_cnt           (lat_cnt),
      .dividend_tdata    (dividend_tdata),
      .divisor_tdata     (divisor_tdata),
      .s_dividend_tvalid (s_dividend_tvalid),
      .s_divisor_tvalid  (s_divisor_tvalid),
      .u_dividend_tvalid (u_dividend_tvalid),
      .u_divisor_tvalid  (u_divisor_tvalid),
      .s_dividend_tready (s_dividend_tready),
      .s_divisor_tready  (s_divisor_tready),
      .u_dividend_tready (u_dividend_tready),
      .u_divisor_tready  (u_divisor_tready),
      .s_dout_tvalid     (s_dout_tvalid),
      .s_dout_tdata      (s_dout_tdata),
      .u_dout_tvalid     (u_dout_tvalid),
      .u_dout_tdata      (u_dout_tdata)
   );

   int checks   = 0;
   int failures = 0;

   logic [2*DATA_W-1:0] exp_q[$];
   logic [2*DATA_W-1:0] last_exp;
   logic [DATA_W-1:0]   core_s_a = '0, core_s_b = '0, core_u_a = '0, core_u_b = '0;

   // Core models: latch operands on each completed handshake.
   always @(posedge clk) begin
      if (s_dividend_tvalid && s_dividend_tready) core_s_a <= dividend_tdata;
      if (s_divisor_tvalid  && s_divisor_tready)  core_s_b <= divisor_tdata;
      if (u_dividend_tvalid && u_dividend_tready) core_u_a <= dividend_tdata;
      if (u_divisor_tvalid  && u_divisor_tready)  core_u_b <= divisor_tdata;
   end

   // Truncating division, result packed {rem, quot}.
   function automatic logic [2*DATA_W-1:0] ref_div(input logic sgn,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
      logic signed [DATA_W-1:0] sa, sb, sq, sr;
      if (sgn) begin
         sa = a;
         sb = b;
         sq = sa / sb;
         sr = sa % sb;
         return {sr, sq};
      end
      return {a % b, a / b};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [2*DATA_W-1:0] obs,
                        input logic [2*DATA_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_tv(input string tag, input logic [3:0] exp);
      check(tag, {s_dividend_tvalid, s_divisor_tvalid, u_dividend_tvalid, u_divisor_tvalid},
            exp);
   endtask

   task automatic check_result(input string tag);
      check({tag, "_done"}, done, 1'b1);
      check({tag, "_sb_nonempty"}, exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
         last_exp = exp_q.pop_front();
         check({tag, "_result"}, {rem, quot}, last_exp);
      end
   endtask

   // Drive a request for one cycle; returns just after the edge that issues it.
   task automatic issue(input logic sgn, input logic [DATA_W-1:0] a,
                        input logic [DATA_W-1:0] b, input logic expect_done);
      req_valid    = 1'b1;
      req_signed   = sgn;
      req_dividend = a;
      req_divisor  = b;
      if (expect_done) exp_q.push_back(ref_div(sgn, a, b));
      tick();
      req_valid = 1'b0;
   endtask

   // One-cycle result pulse from the given core, built from its captured operands.
   task automatic pulse_dout(input logic sgn);
      if (sgn) begin
         s_dout_tdata  = ref_div(1'b1, core_s_a, core_s_b);
         s_dout_tvalid = 1'b1;
      end else begin
         u_dout_tdata  = ref_div(1'b0, core_u_a, core_u_b);
         u_dout_tvalid = 1'b1;
      end
      tick();
      s_dout_tvalid = 1'b0;
      u_dout_tvalid = 1'b0;
   endtask

   task automatic accept();
      res_accept = 1'b1;
      tick();
      res_accept = 1'b0;
   endtask

   task automatic set_readies(input logic v);
      s_dividend_tready = v;
      s_divisor_tready  = v;
      u_dividend_tready = v;
      u_divisor_tready  = v;
   endtask

   initial begin
      reset        = 1'b1;
      req_valid    = 1'b0;
      req_signed   = 1'b0;
      req_dividend = '0;
      req_divisor  = '0;
      flush        = 1'b0;
      res_accept   = 1'b0;
      s_dout_tvalid = 1'b0;
      u_dout_tvalid = 1'b0;
      s_dout_tdata  = '0;
      u_dout_tdata  = '0;
      set_readies(1'b1);
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_quot_rem", {rem, quot}, '0);
      check("rst_lat", lat_cnt, '0);
      check_tv("rst_tvalid", 4'b0000);
      tick();
      tick();
      reset = 1'b0;
      tick();

      // Signed -7 / 2, readies high, core latency 4.
      issue(1'b1, -32'sd7, 32'sd2, 1'b1);
      check_tv("t1_issue_tv", 4'b1100);
      check("t1_tdata", {dividend_tdata, divisor_tdata}, {32'hFFFF_FFF9, 32'd2});
      check("t1_busy", busy, 1'b1);
      tick();
      check_tv("t1_wait_tv", 4'b0000);
      repeat (4) tick();
      check("t1_done_early", done, 1'b0);
      pulse_dout(1'b1);
      check_result("t1");
      check("t1_lat", lat_cnt, 6);
      accept();
      check("t1_idle", {busy, done}, 2'b00);

      // Unsigned 100 / 7, divisor ready arrives 3 cycles after dividend handshake.
      u_divisor_tready = 1'b0;
      issue(1'b0, 32'd100, 32'd7, 1'b1);
      check_tv("t2_issue_tv", 4'b0011);
      tick();
      check_tv("t2_dvd_done", 4'b0001);
      tick();
      check_tv("t2_dvs_hold1", 4'b0001);
      tick();
      check_tv("t2_dvs_hold2", 4'b0001);
      u_divisor_tready = 1'b1;
      tick();
      check_tv("t2_wait_tv", 4'b0000);
      check("t2_busy", busy, 1'b1);
      tick();
      pulse_dout(1'b0);
      check_result("t2");
      check("t2_value", {rem, quot}, {32'd2, 32'd14});

      // Result holds while not accepted.
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t3_hold_done", done, 1'b1);
         check("t3_hold_result", {rem, quot}, last_exp);
      end
      accept();
      check("t3_idle", {busy, done}, 2'b00);

      // Flush 2 cycles into WAIT with a new request pending.
      issue(1'b1, 32'd50, -32'sd3, 1'b0);
      tick();
      tick();
      tick();
      flush        = 1'b1;
      req_valid    = 1'b1;
      req_signed   = 1'b0;
      req_dividend = 32'd9;
      req_divisor  = 32'd4;
      tick();
      flush = 1'b0;
      check("t4_drain_busy", busy, 1'b1);
      check_tv("t4_drain_tv", 4'b0000);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_tv("t4_req_ignored", 4'b0000);
         check("t4_no_done", done, 1'b0);
      end
      pulse_dout(1'b1);
      check("t4_back_idle", {busy, done}, 2'b00);
      exp_q.push_back(ref_div(1'b0, 32'd9, 32'd4));
      tick();
      req_valid = 1'b0;
      check_tv("t4_new_issue", 4'b0011);
      tick();
      tick();
      pulse_dout(1'b0);
      check_result("t4");
      accept();

      // Flush in ISSUE while readies are low.
      set_readies(1'b0);
      issue(1'b0, 32'd20, 32'd3, 1'b0);
      check_tv("t5_issue_tv", 4'b0011);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check_tv("t5_tv_held1", 4'b0011);
      tick();
      check_tv("t5_tv_held2", 4'b0011);
      set_readies(1'b1);
      tick();
      check_tv("t5_drain_tv", 4'b0000);
      check("t5_drain", {busy, done}, 2'b10);
      pulse_dout(1'b0);
      check("t5_idle", {busy, done}, 2'b00);
      tick();
      check("t5_no_done", done, 1'b0);

      // Flush coincident with dout.
      issue(1'b1, 32'd15, 32'd4, 1'b0);
      tick();
      tick();
      flush = 1'b1;
      pulse_dout(1'b1);
      flush = 1'b0;
      check("t6_idle", {busy, done}, 2'b00);
      tick();
      check("t6_no_done", done, 1'b0);

      // Asynchronous reset mid-WAIT, then a stale dout.
      issue(1'b0, 32'd1000, 32'd10, 1'b0);
      tick();
      tick();
      reset = 1'b1;
      #1;
      check("t7_async_busy", busy, 1'b0);
      check("t7_async_lat", lat_cnt, '0);
      tick();
      reset = 1'b0;
      tick();
      pulse_dout(1'b0);
      check("t7_stale_ignored", {busy, done}, 2'b00);
      check("t7_outputs_zero", {rem, quot}, '0);
      check("t7_tdata_zero", {dividend_tdata, divisor_tdata}, '0);
      check("t7_lat_zero", lat_cnt, '0);
      check_tv("t7_tv_zero", 4'b0000);

      // Long core latency: lat_cnt saturates.
      issue(1'b0, 32'd7, 32'd7, 1'b1);
      tick();
      repeat (70) tick();
      check("t8_lat_sat", lat_cnt, {LAT_W{1'b1}});
      check("t8_waiting", {busy, done}, 2'b10);
      pulse_dout(1'b0);
      check_result("t8");
      check("t8_lat_sat_done", lat_cnt, {LAT_W{1'b1}});
      accept();
      check("t8_idle", {busy, done}, 2'b00);

      check("sb_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
